// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO writer and the mfhi/mflo read side.
package hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_NOP2  = 3'b111;

    localparam logic [1:0] ALU_MFHI = 2'b01;
    localparam logic [1:0] ALU_MFLO = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared iterative datapath: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   sum, shifted, diff;

    always_comb begin
        sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        shifted = {acc_q, q_q[WIDTH-1]};
        diff    = shifted - {1'b0, m_q};
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        div_d   = div_q;
        if (load) begin
            acc_d = '0;
            q_d   = a;
            m_d   = b;
            div_d = div_mode;
        end else if (step) begin
            if (div_q) begin
                // Non-negative trial difference means the divisor fits: keep it, shift in a 1.
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = sum[WIDTH:1];
                q_d   = {sum[0], q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            q_q   <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign acc = acc_q;
    assign q   = q_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO writer: multicycle MULTU/DIVU (MULT/DIV with HILO_SIGNED_OPS_EN), single-cycle MTHI/MTLO.
// Macro HILO_SIGNED_OPS_EN: when undefined, ops 011/100 behave as MULTU/DIVU.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import hilo_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             load, step, op_div;
    logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo, res_hi, res_lo;

    assign op_div = is_div_op(op);

`ifdef HILO_SIGNED_OPS_EN
    logic is_div_q, is_div_d, neg_ab_q, neg_ab_d, neg_a_q, neg_a_d;
    logic op_signed, a_neg, b_neg, div_zero;

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & rs[WIDTH-1];
        b_neg     = op_signed & rt[WIDTH-1];
        // Divide by zero must return the raw dividend in HI, so skip all sign handling.
        div_zero  = op_div && (rt == '0);
        a_mag     = (a_neg && !div_zero) ? -rs : rs;
        b_mag     = b_neg ? -rt : rt;
        is_div_d  = load ? op_div : is_div_q;
        neg_ab_d  = load ? ((a_neg ^ b_neg) & ~div_zero) : neg_ab_q;
        neg_a_d   = load ? (a_neg & ~div_zero) : neg_a_q;
        if (is_div_q) begin
            res_hi = neg_a_q ? -core_hi : core_hi;
            res_lo = neg_ab_q ? -core_lo : core_lo;
        end else begin
            {res_hi, res_lo} = neg_ab_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            neg_ab_q <= 1'b0;
            neg_a_q  <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
            neg_ab_q <= neg_ab_d;
            neg_a_q  <= neg_a_d;
        end
    end
`else
    assign a_mag  = rs;
    assign b_mag  = rt;
    assign res_hi = core_hi;
    assign res_lo = core_lo;
`endif

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .div_mode(op_div),
        .a       (a_mag),
        .b       (b_mag),
        .acc     (core_hi),
        .q       (core_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_muldiv(op)) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs;
                    end
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized checks of hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  rs = '0;
    logic [W-1:0]  rt = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .rs   (rs),
        .rt   (rt),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result of a mul/div op, straight from the architectural definition.
    function automatic logic [2*W-1:0] ref_muldiv(input logic [2:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        longint sa, sb;
        logic [2*W-1:0] r;
        logic [2:0] eo;
        eo = o;
`ifndef HILO_SIGNED_OPS_EN
        if (o == 3'b011) eo = 3'b001;
        if (o == 3'b100) eo = 3'b010;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (eo)
            3'b001: r = {32'b0, a} * {32'b0, b};
            3'b011: r = sa * sb;
            3'b010, 3'b100: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (eo == 3'b010) r = {a % b, a / b};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: r = {hi_m, lo_m};
        endcase
        return r;
    endfunction

    task automatic do_muldiv(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eh, input logic [W-1:0] el, input string tag);
        logic early;
        early = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_acc"}, {31'b0, busy}, 32'd1);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (done) early = 1'b1;
            // Requests while busy must be dropped without effect.
            if (i == 5) begin start = 1'b1; op = 3'b101; rs = $urandom; end
            if (i == 12) begin start = 1'b1; op = 3'b001; rs = $urandom; rt = $urandom; end
            if (i == 6 || i == 13) start = 1'b0;
        end
        check({tag, ".early_done"}, {31'b0, early}, 32'd0);
        check({tag, ".busy_last"}, {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        check({tag, ".done"}, {31'b0, done}, 32'd1);
        check({tag, ".busy_fin"}, {31'b0, busy}, 32'd0);
        check({tag, ".hi"}, hi, eh);
        check({tag, ".lo"}, lo, el);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
        hi_m = eh;
        lo_m = el;
    endtask

    task automatic do_single(input logic [2:0] o, input logic [W-1:0] a, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        if (o == 3'b101) hi_m = a;
        if (o == 3'b110) lo_m = a;
        check({tag, ".hi"}, hi, hi_m);
        check({tag, ".lo"}, lo, lo_m);
        check({tag, ".busy_done"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [2:0]     o;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] r;
        logic           saw_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        check("reset.busy_done", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_single(3'b101, 32'h1234_5678, "mthi");
        do_single(3'b110, 32'h9ABC_DEF0, "mtlo");
        do_single(3'b000, 32'hDEAD_BEEF, "nop");
        do_single(3'b111, 32'hCAFE_F00D, "nop7");

        do_muldiv(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        do_muldiv(3'b010, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
        do_muldiv(3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_by0");
`ifdef HILO_SIGNED_OPS_EN
        do_muldiv(3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        do_muldiv(3'b011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1_1");
        do_muldiv(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        do_muldiv(3'b100, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, "div_by0_neg");
`else
        do_muldiv(3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "op3_unsigned");
        do_muldiv(3'b100, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, "op4_unsigned");
`endif

        for (int k = 0; k < 24; k++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (o >= 3'd1 && o <= 3'd4) begin
                r = ref_muldiv(o, a, b);
                do_muldiv(o, a, b, r[2*W-1:W], r[W-1:0], $sformatf("rnd%0d_op%0d", k, o));
            end else begin
                do_single(o, a, $sformatf("rnd%0d_op%0d", k, o));
            end
        end

        // Abort mid-DIVU: async reset clears everything and no late result appears.
        do_single(3'b101, 32'hA5A5_A5A5, "pre_abort");
        @(negedge clk);
        start = 1'b1; op = 3'b010; rs = 32'd1000; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.busy_done", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort.no_done", {31'b0, saw_done}, 32'd0);
        check("abort.hi_hold", hi, 32'd0);
        check("abort.lo_hold", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
